// File: rtl/as_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : as_pipe_ctrl
// Brief    : Five-stage pipeline hazard controller. Resolves data-memory
//            freezes, taken-branch redirects and load-use bubbles into PC and
//            pipeline-register enable/flush controls. Also provides a sticky
//            frozen-PC watchdog and optional saturating performance counters.
// Config   : define AS_PERF_CNT_EN to build the stall/flush counters;
//            without it both counter outputs are constant zero.
// Revision : 1.0 - initial release
// ============================================================================
module as_pipe_ctrl #(
  parameter int MAX_STALL = 16,  // frozen-PC cycles before hang_o (2..255)
  parameter int CNT_W     = 32   // performance counter width
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_n_i,
  input  logic             branch_taken_i,
  input  logic             dmem_busy_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             id_ex_en_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             hang_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_ST_RUN    = 2'd0;
  localparam logic [1:0] c_ST_BUBBLE = 2'd1;
  localparam logic [1:0] c_ST_FREEZE = 2'd2;

  // Watchdog counter only needs to reach MAX_STALL, where it saturates.
  localparam int                c_WD_W   = $clog2(MAX_STALL + 1);
  localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(MAX_STALL);
  localparam logic [c_WD_W-1:0] c_WD_ONE = c_WD_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;

  logic              w_pc_en;
  logic              w_if_id_en;
  logic              w_id_ex_en;
  logic              w_ex_mem_en;
  logic              w_mem_wb_en;
  logic              w_if_id_flush;
  logic              w_id_ex_flush;

  // A load-use stall is only honoured outside BUBBLE; the instruction that
  // raised it has already been separated from its consumer by the bubble.
  logic              w_stall_req;

  logic [c_WD_W-1:0] r_wd_cnt;
  logic [c_WD_W-1:0] w_wd_nxt;
  logic              r_hang;

  assign w_stall_req = ~stall_n_i && (r_state != c_ST_BUBBLE);

  // --------------------------------------------------------------------------
  // FSM: state register (reset returns to RUN from any state)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next-state selection in priority order busy > branch > stall
  always_comb begin
    w_state_nxt = c_ST_RUN;
    if (dmem_busy_i) begin
      w_state_nxt = c_ST_FREEZE;
    end else if (branch_taken_i) begin
      w_state_nxt = c_ST_RUN;
    end else if (w_stall_req) begin
      w_state_nxt = c_ST_BUBBLE;
    end else begin
      w_state_nxt = c_ST_RUN;
    end
  end

  // FSM: combinational enables and flushes for the current cycle
  always_comb begin
    // normal advance
    w_pc_en       = 1'b1;
    w_if_id_en    = 1'b1;
    w_id_ex_en    = 1'b1;
    w_ex_mem_en   = 1'b1;
    w_mem_wb_en   = 1'b1;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    if (rst_i) begin
      // hold everything and keep NOPs in the front-end registers
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_en    = 1'b0;
      w_ex_mem_en   = 1'b0;
      w_mem_wb_en   = 1'b0;
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (dmem_busy_i) begin
      // whole-pipeline freeze; held branch/stall inputs are acted on later
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_en    = 1'b0;
      w_ex_mem_en   = 1'b0;
      w_mem_wb_en   = 1'b0;
    end else if (branch_taken_i) begin
      // redirect: squash the two wrong-path instructions behind execute
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_stall_req) begin
      // load-use: hold PC and IF/ID, push a bubble into ID/EX
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_flush = 1'b1;
    end
  end

  assign pc_en_o       = w_pc_en;
  assign if_id_en_o    = w_if_id_en;
  assign id_ex_en_o    = w_id_ex_en;
  assign ex_mem_en_o   = w_ex_mem_en;
  assign mem_wb_en_o   = w_mem_wb_en;
  assign if_id_flush_o = w_if_id_flush;
  assign id_ex_flush_o = w_id_ex_flush;

  // --------------------------------------------------------------------------
  // Watchdog: consecutive frozen-PC cycles, saturating at MAX_STALL
  // --------------------------------------------------------------------------
  // Next watchdog count: clear on PC advance, otherwise count up to the limit
  always_comb begin
    w_wd_nxt = r_wd_cnt;
    if (w_pc_en) begin
      w_wd_nxt = '0;
    end else if (r_wd_cnt != c_WD_MAX) begin
      w_wd_nxt = r_wd_cnt + c_WD_ONE;
    end
  end

  // Watchdog register and sticky hang flag; hang rises on the same edge at
  // which the count lands on MAX_STALL and is only cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wd_cnt <= '0;
      r_hang   <= 1'b0;
    end else begin
      r_wd_cnt <= w_wd_nxt;
      if (w_wd_nxt == c_WD_MAX) begin
        r_hang <= 1'b1;
      end
    end
  end

  assign hang_o = r_hang;

  // --------------------------------------------------------------------------
  // Performance counters
  // --------------------------------------------------------------------------
`ifdef AS_PERF_CNT_EN
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Saturating counts of frozen-PC cycles and IF/ID flush cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!w_pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
      end
      if (w_if_id_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign stall_cnt_o = {CNT_W{1'b0}};
  assign flush_cnt_o = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_as_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_as_pipe_ctrl
// Brief    : Scoreboard bench for as_pipe_ctrl. A driver applies one directed
//            vector per cycle and queues its hand-computed expectation; a
//            monitor samples the DUT each cycle and compares against the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_as_pipe_ctrl;

  localparam int c_MAX_STALL = 16;
  localparam int c_CNT_W     = 4;

  // control vector order: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_fl, id_ex_fl}
  localparam logic [6:0] c_ADV = 7'b11111_00;
  localparam logic [6:0] c_BR  = 7'b11111_11;
  localparam logic [6:0] c_STL = 7'b00111_01;
  localparam logic [6:0] c_FRZ = 7'b00000_00;
  localparam logic [6:0] c_RST = 7'b00000_11;

  typedef struct packed {
    logic [6:0]         ctl;
    logic               hang;
    logic [c_CNT_W-1:0] scnt;
    logic [c_CNT_W-1:0] fcnt;
  } exp_t;

  logic               clk_i = 1'b0;
  logic               rst_i = 1'b1;
  logic               stall_n_i = 1'b1;
  logic               branch_taken_i = 1'b0;
  logic               dmem_busy_i = 1'b0;
  logic               pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
  logic               if_id_flush_o, id_ex_flush_o, hang_o;
  logic [c_CNT_W-1:0] stall_cnt_o, flush_cnt_o;

  exp_t q_exp[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   done     = 1'b0;

  as_pipe_ctrl #(
    .MAX_STALL(c_MAX_STALL),
    .CNT_W    (c_CNT_W)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_n_i     (stall_n_i),
    .branch_taken_i(branch_taken_i),
    .dmem_busy_i   (dmem_busy_i),
    .pc_en_o       (pc_en_o),
    .if_id_en_o    (if_id_en_o),
    .id_ex_en_o    (id_ex_en_o),
    .ex_mem_en_o   (ex_mem_en_o),
    .mem_wb_en_o   (mem_wb_en_o),
    .if_id_flush_o (if_id_flush_o),
    .id_ex_flush_o (id_ex_flush_o),
    .hang_o        (hang_o),
    .stall_cnt_o   (stall_cnt_o),
    .flush_cnt_o   (flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %b required %b (t=%0t)", name, act, req, $time);
  endtask

  // One cycle of stimulus; ctl is the same-cycle output, the rest are the
  // register values expected just after the closing clock edge.
  task automatic cyc(input logic rst, input logic stn, input logic br, input logic busy,
                     input logic [6:0] ctl, input logic hang,
                     input int scnt, input int fcnt);
    exp_t e;
    @(negedge clk_i);
    rst_i          = rst;
    stall_n_i      = stn;
    branch_taken_i = br;
    dmem_busy_i    = busy;
    e.ctl  = ctl;
    e.hang = hang;
`ifdef AS_PERF_CNT_EN
    e.scnt = c_CNT_W'(scnt);
    e.fcnt = c_CNT_W'(fcnt);
`else
    e.scnt = '0;
    e.fcnt = '0;
`endif
    q_exp.push_back(e);
  endtask

  // Monitor: combinational outputs mid-cycle, registers after the edge
  initial begin : p_monitor
    logic [6:0] ctl_s;
    exp_t       e;
    forever begin
      @(negedge clk_i);
      #2;
      ctl_s = {pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
               if_id_flush_o, id_ex_flush_o};
      @(posedge clk_i);
      #1;
      if (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        check("ctl",   ctl_s, e.ctl);
        check("hang",  {6'd0, hang_o}, {6'd0, e.hang});
        check("stall_cnt", 7'(stall_cnt_o), 7'(e.scnt));
        check("flush_cnt", 7'(flush_cnt_o), 7'(e.fcnt));
      end
    end
  end

  // Driver: directed sequences with hand-computed results
  initial begin : p_driver
    // reset state
    cyc(1, 1, 0, 0, c_RST, 0, 0, 0);
    cyc(1, 0, 1, 1, c_RST, 0, 0, 0);

    // load-use stall held for two cycles: bubble then advance
    cyc(0, 0, 0, 0, c_STL, 0, 1, 0);
    cyc(0, 0, 0, 0, c_ADV, 0, 1, 0);
    cyc(0, 1, 0, 0, c_ADV, 0, 1, 0);

    // branch together with stall: stall discarded
    cyc(1, 1, 0, 0, c_RST, 0, 0, 0);
    cyc(0, 0, 1, 0, c_BR,  0, 0, 1);
    cyc(0, 1, 0, 0, c_ADV, 0, 0, 1);

    // busy with stall for 3 cycles, bubble in the 4th
    cyc(1, 1, 0, 0, c_RST, 0, 0, 0);
    cyc(0, 0, 0, 1, c_FRZ, 0, 1, 0);
    cyc(0, 0, 0, 1, c_FRZ, 0, 2, 0);
    cyc(0, 0, 0, 1, c_FRZ, 0, 3, 0);
    cyc(0, 0, 0, 0, c_STL, 0, 4, 0);
    cyc(0, 0, 0, 0, c_ADV, 0, 4, 0);

    // branch held through a freeze, then branch out of BUBBLE
    cyc(0, 1, 1, 1, c_FRZ, 0, 5, 0);
    cyc(0, 1, 1, 0, c_BR,  0, 5, 1);
    cyc(0, 0, 0, 0, c_STL, 0, 6, 1);
    cyc(0, 0, 1, 0, c_BR,  0, 6, 2);

    // reset while in BUBBLE, next stall inserts a bubble from RUN
    cyc(0, 0, 0, 0, c_STL, 0, 7, 2);
    cyc(1, 0, 0, 0, c_RST, 0, 0, 0);
    cyc(0, 0, 0, 0, c_STL, 0, 1, 0);
    // busy overrides BUBBLE, then reset mid-FREEZE
    cyc(0, 1, 0, 1, c_FRZ, 0, 2, 0);
    cyc(1, 1, 0, 1, c_RST, 0, 0, 0);
    cyc(0, 1, 0, 0, c_ADV, 0, 0, 0);

    // watchdog: 20 frozen cycles, hang at cycle 16, counter saturates at 15
    cyc(1, 1, 0, 0, c_RST, 0, 0, 0);
    for (int i = 1; i <= 20; i++)
      cyc(0, 1, 0, 1, c_FRZ, (i >= 16), (i > 15) ? 15 : i, 0);
    cyc(0, 1, 0, 0, c_ADV, 1, 15, 0);
    cyc(0, 1, 0, 0, c_ADV, 1, 15, 0);
    cyc(1, 1, 0, 0, c_RST, 0, 0, 0);
    cyc(0, 1, 0, 0, c_ADV, 0, 0, 0);

    // watchdog clears on any PC advance: 15 + 1 advance + 15 never hangs
    for (int i = 1; i <= 15; i++)
      cyc(0, 1, 0, 1, c_FRZ, 0, i, 0);
    cyc(0, 1, 0, 0, c_ADV, 0, 15, 0);
    for (int i = 1; i <= 15; i++)
      cyc(0, 1, 0, 1, c_FRZ, 0, 15, 0);
    cyc(0, 1, 0, 0, c_ADV, 0, 15, 0);

    repeat (3) @(negedge clk_i);
    done = 1'b1;
  end

  // Completion and timeout
  initial begin : p_end
    fork
      wait (done);
      #20000;
    join_any
    disable fork;
    if (!done) begin
      n_checks++;
      $display("FAIL timeout: driver not done, required done");
    end
    n_checks++;
    if (q_exp.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d left required 0", q_exp.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/as_pipe_ctrl.md
AS_PIPE_CTRL -- requirements
Module: as_pipe_ctrl

Interface
REQ-001 Parameter MAX_STALL, default 16: consecutive frozen-PC cycles that set hang_o; legal range 2..255.
REQ-002 Parameter CNT_W, default 32: width of both performance counters.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 stall_n_i  input  1  load-use hazard indication from the hazard detector; 0 = stall request.
REQ-006 branch_taken_i  input  1  taken branch or jump resolved in execute; 1 = redirect.
REQ-007 dmem_busy_i  input  1  data memory not ready; 1 = whole pipeline freeze.
REQ-008 pc_en_o  output  1  PC register load enable.
REQ-009 if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  output  1 each  pipeline register enables.
REQ-010 if_id_flush_o, id_ex_flush_o  output  1 each  load a NOP bubble into IF/ID or ID/EX.
REQ-011 hang_o  output  1  sticky watchdog error.
REQ-012 stall_cnt_o, flush_cnt_o  output  CNT_W each  performance counters.

Function
REQ-013 The FSM SHALL have three states: RUN, BUBBLE and FREEZE; all control outputs SHALL be combinational from the state and inputs, in the same cycle.
REQ-014 Priority SHALL be: dmem_busy_i, then branch_taken_i, then the stall request (stall_n_i=0).
REQ-015 With dmem_busy_i=1 in any state: all enables SHALL be 0 and all flushes 0; the next state SHALL be FREEZE.
REQ-016 FREEZE with dmem_busy_i=0 SHALL evaluate the inputs exactly as RUN does; the held branch_taken_i and stall_n_i are acted on in the first non-busy cycle.
REQ-017 A branch (branch_taken_i=1, dmem_busy_i=0) SHALL drive:
  - pc_en_o=1 and all enables 1;
  - if_id_flush_o=1 and id_ex_flush_o=1;
  - a concurrent stall request is discarded;
  - next state RUN.
REQ-018 A stall request in RUN or FREEZE (with branch_taken_i=0 and dmem_busy_i=0) SHALL drive:
  - pc_en_o=0 and if_id_en_o=0;
  - id_ex_en_o=1 and id_ex_flush_o=1;
  - ex_mem_en_o=1 and mem_wb_en_o=1;
  - next state BUBBLE.
REQ-019 In BUBBLE, stall_n_i SHALL be ignored: the controller drives normal advance (all enables 1, flushes 0) unless a busy or branch condition overrides; the next state SHALL then be RUN.
REQ-020 Normal advance SHALL be: all enables 1, both flushes 0.
REQ-021 The watchdog SHALL count consecutive cycles with pc_en_o=0 and clear when pc_en_o=1.
REQ-022 When the watchdog count reaches MAX_STALL, hang_o SHALL set and hold 1 until reset; the count SHALL saturate at MAX_STALL.
REQ-023 stall_cnt_o SHALL increment by 1 on every non-reset cycle with pc_en_o=0.
REQ-024 flush_cnt_o SHALL increment by 1 on every cycle in which if_id_flush_o=1.
REQ-025 Both counters SHALL saturate at all-ones and never wrap.

Reset
REQ-026 While rst_i=1 the block SHALL drive: state RUN, pc_en_o=0, all enables 0, if_id_flush_o=1, id_ex_flush_o=1.
REQ-027 While rst_i=1 the watchdog count, hang_o and both counters SHALL be 0, and no counter SHALL increment.
REQ-028 Reset SHALL take effect in the same cycle regardless of state, including mid-FREEZE and mid-BUBBLE.
REQ-029 In the first cycle after rst_i falls, the block SHALL behave as RUN.

Configuration
REQ-030 With macro AS_PERF_CNT_EN defined, stall_cnt_o and flush_cnt_o SHALL operate per REQ-023 to REQ-025.
REQ-031 Without AS_PERF_CNT_EN, no counter registers SHALL exist and both outputs SHALL be tied to 0; all other behaviour SHALL be unchanged.

Verification
REQ-032 Stall: stall_n_i=0 for 2 cycles from RUN -> cycle 1: pc_en_o=0, id_ex_flush_o=1; cycle 2 (BUBBLE): pc_en_o=1, id_ex_flush_o=0; stall_cnt_o=1.
REQ-033 Branch with stall: branch_taken_i=1 and stall_n_i=0 in the same cycle -> pc_en_o=1, if_id_flush_o=1, id_ex_flush_o=1; flush_cnt_o=1; stall_cnt_o=0.
REQ-034 Busy with stall: dmem_busy_i=1 for 3 cycles together with stall_n_i=0 -> all enables 0 for 3 cycles; in the 4th cycle the load-use bubble is inserted; stall_cnt_o=4.
REQ-035 Watchdog: dmem_busy_i=1 for 20 cycles with MAX_STALL=16 -> hang_o rises at the end of cycle 16 and stays 1 after busy drops; it clears only on rst_i.
REQ-036 Reset in BUBBLE: rst_i=1 for one cycle while in BUBBLE -> both flushes 1 and counters 0 during reset; the next cycle with stall_n_i=0 inserts a bubble (state was RUN).
REQ-037 Saturation: with CNT_W=4 and AS_PERF_CNT_EN defined, 20 frozen cycles -> stall_cnt_o holds 15; without the macro -> stall_cnt_o=0 throughout.
